// File: rtl/instr_bus_router.sv
// Instruction-side bus router: decodes each fetch address to the boot ROM,
// the SRAM or a local error responder, forwards the req/gnt handshake and
// returns responses to the core strictly in order.
module instr_bus_router #(
   parameter logic [31:0] ROM_BASE        = 32'h0000_0000,
   parameter logic [31:0] ROM_MASK        = 32'hFFFF_F000,
   parameter logic [31:0] SRAM_BASE       = 32'h1000_0000,
   parameter logic [31:0] SRAM_MASK       = 32'hFFFF_0000,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [6:0]  ERR_INTG        = 7'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        host_req_i,
   input  logic [31:0] host_addr_i,
   output logic        host_gnt_o,
   output logic        host_rvalid_o,
   output logic [31:0] host_rdata_o,
   output logic [6:0]  host_rdata_intg_o,
   output logic        host_err_o,
   output logic        rom_req_o,
   output logic [31:0] rom_addr_o,
   input  logic        rom_gnt_i,
   input  logic        rom_rvalid_i,
   input  logic [31:0] rom_rdata_i,
   input  logic [6:0]  rom_rdata_intg_i,
   input  logic        rom_err_i,
   output logic        sram_req_o,
   output logic [31:0] sram_addr_o,
   input  logic        sram_gnt_i,
   input  logic        sram_rvalid_i,
   input  logic [31:0] sram_rdata_i,
   input  logic [6:0]  sram_rdata_intg_i,
   input  logic        sram_err_i,
   output logic        unmapped_o
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {TGT_NONE, TGT_ROM, TGT_SRAM, TGT_ERR} tgt_e;

   tgt_e          cur_tgt;
   tgt_e          dec_tgt;
   tgt_e          rsp_tgt;
   logic [CW-1:0] count;
   logic          pending;
   logic          held_rsp;
   logic          slot_free;
   logic          issue;
   logic          tgt_gnt;
   logic          hs;

   // Address decode; ROM wins when regions overlap.
   always_comb begin
      if ((host_addr_i & ROM_MASK) == ROM_BASE)
         dec_tgt = TGT_ROM;
      else if ((host_addr_i & SRAM_MASK) == SRAM_BASE)
         dec_tgt = TGT_SRAM;
      else
         dec_tgt = TGT_ERR;
   end

   // Response retiring from the already-outstanding target; kept independent
   // of this cycle's grant so a freed slot can be refilled without a loop.
   always_comb begin
      // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
      held_rsp = 1'b0;
      if (rst && (count != '0)) begin
         unique case (cur_tgt)
            TGT_ROM:  held_rsp = rom_rvalid_i;
            TGT_SRAM: held_rsp = sram_rvalid_i;
            TGT_ERR:  held_rsp = pending;
            default:  held_rsp = 1'b0;
         endcase
      end
   end

   // Issue gating and request forwarding to the decoded target.
   always_comb begin
      slot_free   = (count < MAX_CNT) || held_rsp;
      issue       = rst && host_req_i && slot_free &&
                    ((count == '0) || (dec_tgt == cur_tgt));
      rom_req_o   = issue && (dec_tgt == TGT_ROM);
      sram_req_o  = issue && (dec_tgt == TGT_SRAM);
      rom_addr_o  = host_addr_i;
      sram_addr_o = host_addr_i;
      tgt_gnt     = 1'b0;
      unique case (dec_tgt)
         TGT_ROM:  tgt_gnt = rom_gnt_i;
         TGT_SRAM: tgt_gnt = sram_gnt_i;
         TGT_ERR:  tgt_gnt = 1'b1;
         default:  tgt_gnt = 1'b0;
      endcase
      hs         = issue && tgt_gnt;
      host_gnt_o = hs;
      unmapped_o = hs && (dec_tgt == TGT_ERR);
   end

   // Response mux; with nothing outstanding only a same-cycle (zero-latency)
   // grant may answer, anything else is a spurious rvalid and is dropped.
   always_comb begin
      if (count != '0)
         rsp_tgt = cur_tgt;
      else if (hs)
         rsp_tgt = dec_tgt;
      else
         rsp_tgt = TGT_NONE;
      host_rvalid_o     = 1'b0;
      host_rdata_o      = '0;
      host_rdata_intg_o = '0;
      host_err_o        = 1'b0;
      if (rst) begin
         unique case (rsp_tgt)
            TGT_ROM: begin
               host_rvalid_o     = rom_rvalid_i;
               host_rdata_o      = rom_rdata_i;
               host_rdata_intg_o = rom_rdata_intg_i;
               host_err_o        = rom_err_i;
            end
            TGT_SRAM: begin
               host_rvalid_o     = sram_rvalid_i;
               host_rdata_o      = sram_rdata_i;
               host_rdata_intg_o = sram_rdata_intg_i;
               host_err_o        = sram_err_i;
            end
            TGT_ERR: begin
               host_rvalid_o     = pending;
               host_rdata_intg_o = ERR_INTG;
               host_err_o        = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Outstanding count, current target and error-responder pending bit.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst) begin
         count   <= '0;
         cur_tgt <= TGT_NONE;
         pending <= 1'b0;
      end else begin
         if (hs && !host_rvalid_o)
            count <= count + CW'(1);
         else if (!hs && host_rvalid_o)
            count <= count - CW'(1);
         if (hs)
            cur_tgt <= dec_tgt;
         pending <= hs && (dec_tgt == TGT_ERR);
      end
   end

endmodule

// File: tb/tb_instr_bus_router.sv
// Directed bench for instr_bus_router: per-cycle handshake checks plus an
// in-order response scoreboard drained by an independent monitor.
module tb_instr_bus_router;

   localparam logic [6:0] ERR_INTG = 7'h00;
   localparam logic [6:0] ROM_INTG = 7'h2A;
   localparam logic [6:0] SRAM_INTG = 7'h11;

   logic        clk = 1'b0;
   logic        rst;
   logic        host_req_i;
   logic [31:0] host_addr_i;
   logic        host_gnt_o, host_rvalid_o, host_err_o, unmapped_o;
   logic [31:0] host_rdata_o;
   logic [6:0]  host_rdata_intg_o;
   logic        rom_req_o, rom_gnt_i, rom_rvalid_i, rom_err_i;
   logic [31:0] rom_addr_o, rom_rdata_i;
   logic [6:0]  rom_rdata_intg_i;
   logic        sram_req_o, sram_gnt_i, sram_rvalid_i, sram_err_i;
   logic [31:0] sram_addr_o, sram_rdata_i;
   logic [6:0]  sram_rdata_intg_i;

   typedef struct packed {
      logic [31:0] data;
      logic [6:0]  intg;
      logic        err;
   } rsp_t;

   rsp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   instr_bus_router dut (
      .clk(clk), .rst(rst),
      .host_req_i(host_req_i), .host_addr_i(host_addr_i), .host_gnt_o(host_gnt_o),
      .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
      .host_rdata_intg_o(host_rdata_intg_o), .host_err_o(host_err_o),
      .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_gnt_i(rom_gnt_i),
      .rom_rvalid_i(rom_rvalid_i), .rom_rdata_i(rom_rdata_i),
      .rom_rdata_intg_i(rom_rdata_intg_i), .rom_err_i(rom_err_i),
      .sram_req_o(sram_req_o), .sram_addr_o(sram_addr_o), .sram_gnt_i(sram_gnt_i),
      .sram_rvalid_i(sram_rvalid_i), .sram_rdata_i(sram_rdata_i),
      .sram_rdata_intg_i(sram_rdata_intg_i), .sram_err_i(sram_err_i),
      .unmapped_o(unmapped_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: every forwarded response must match the oldest expected one.
   always @(negedge clk) begin
      if (host_rvalid_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got rvalid with data %h, expected none (t=%0t)",
                     host_rdata_o, $time);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            check("rsp_data", host_rdata_o, e.data);
            check("rsp_intg", {25'd0, host_rdata_intg_o}, {25'd0, e.intg});
            check("rsp_err", {31'd0, host_err_o}, {31'd0, e.err});
         end
      end
   end

   task automatic idle();
      host_req_i = 1'b0; host_addr_i = '0;
      rom_gnt_i = 1'b0; rom_rvalid_i = 1'b0; rom_rdata_i = '0;
      rom_rdata_intg_i = ROM_INTG; rom_err_i = 1'b0;
      sram_gnt_i = 1'b0; sram_rvalid_i = 1'b0; sram_rdata_i = '0;
      sram_rdata_intg_i = SRAM_INTG; sram_err_i = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a);
      host_req_i = 1'b1;
      host_addr_i = a;
   endtask

   // One cycle: sample handshake outputs mid-cycle, then move past the edge.
   task automatic tick(input string nm, input logic eg, input logic er,
                       input logic es, input logic eu, input logic ev);
      @(negedge clk);
      check({nm, "_gnt"}, {31'd0, host_gnt_o}, {31'd0, eg});
      check({nm, "_rom_req"}, {31'd0, rom_req_o}, {31'd0, er});
      check({nm, "_sram_req"}, {31'd0, sram_req_o}, {31'd0, es});
      check({nm, "_unmapped"}, {31'd0, unmapped_o}, {31'd0, eu});
      check({nm, "_rvalid"}, {31'd0, host_rvalid_o}, {31'd0, ev});
      if (er) check({nm, "_rom_addr"}, rom_addr_o, host_addr_i);
      if (es) check({nm, "_sram_addr"}, sram_addr_o, host_addr_i);
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst = 1'b0;
      @(posedge clk); #1;
      // Reset holds every output low even with a live request and target activity.
      fetch(32'h0000_0010); rom_gnt_i = 1'b1; rom_rvalid_i = 1'b1; rom_rdata_i = 32'h1234_5678;
      tick("reset", 0, 0, 0, 0, 0);
      check("reset_rdata", host_rdata_o, 32'h0);
      check("reset_err", {31'd0, host_err_o}, 32'h0);
      rst = 1'b1; idle();
      tick("idle", 0, 0, 0, 0, 0);

      // Basic ROM fetch, one-cycle target latency.
      fetch(32'h0000_0010); rom_gnt_i = 1'b1;
      exp_q.push_back('{32'h0000_0013, ROM_INTG, 1'b0});
      tick("rom_gnt", 1, 1, 0, 0, 0);
      idle(); rom_rvalid_i = 1'b1; rom_rdata_i = 32'h0000_0013;
      tick("rom_rsp", 0, 0, 0, 0, 1);

      // Pipelined ROM fetches up to the outstanding limit.
      idle(); fetch(32'h0000_0020); rom_gnt_i = 1'b1;
      exp_q.push_back('{32'hA000_0001, ROM_INTG, 1'b0});
      tick("pipe_g1", 1, 1, 0, 0, 0);
      fetch(32'h0000_0024);
      exp_q.push_back('{32'hA000_0002, ROM_INTG, 1'b0});
      tick("pipe_g2", 1, 1, 0, 0, 0);
      fetch(32'h0000_0028);
      tick("pipe_full", 0, 0, 0, 0, 0);
      rom_rvalid_i = 1'b1; rom_rdata_i = 32'hA000_0001;
      exp_q.push_back('{32'hA000_0003, ROM_INTG, 1'b0});
      tick("pipe_g3_r1", 1, 1, 0, 0, 1);
      rom_rvalid_i = 1'b0; fetch(32'h0000_002C);
      tick("pipe_still_full", 0, 0, 0, 0, 0);
      rom_rvalid_i = 1'b1; rom_rdata_i = 32'hA000_0002;
      exp_q.push_back('{32'hA000_0004, ROM_INTG, 1'b0});
      tick("pipe_g4_r2", 1, 1, 0, 0, 1);
      idle(); rom_rvalid_i = 1'b1; rom_rdata_i = 32'hA000_0003;
      tick("pipe_r3", 0, 0, 0, 0, 1);
      rom_rdata_i = 32'hA000_0004;
      tick("pipe_r4", 0, 0, 0, 0, 1);

      // Target switch stalls until the ROM fetch has drained.
      idle(); fetch(32'h0000_0030); rom_gnt_i = 1'b1;
      exp_q.push_back('{32'h0000_0033, ROM_INTG, 1'b0});
      tick("sw_rom", 1, 1, 0, 0, 0);
      idle(); fetch(32'h1000_0000); sram_gnt_i = 1'b1;
      tick("sw_stall", 0, 0, 0, 0, 0);
      rom_rvalid_i = 1'b1; rom_rdata_i = 32'h0000_0033;
      tick("sw_stall_rsp", 0, 0, 0, 0, 1);
      rom_rvalid_i = 1'b0;
      exp_q.push_back('{32'hCAFE_F00D, SRAM_INTG, 1'b0});
      tick("sw_sram", 1, 0, 1, 0, 0);
      idle(); sram_rvalid_i = 1'b1; sram_rdata_i = 32'hCAFE_F00D;
      tick("sw_sram_rsp", 0, 0, 0, 0, 1);

      // Unmapped fetch and back-to-back error responses.
      idle(); fetch(32'h8000_0000);
      exp_q.push_back('{32'h0, ERR_INTG, 1'b1});
      tick("err_gnt", 1, 0, 0, 1, 0);
      idle();
      tick("err_rsp", 0, 0, 0, 0, 1);
      fetch(32'h8000_0004);
      exp_q.push_back('{32'h0, ERR_INTG, 1'b1});
      tick("err_b2b_1", 1, 0, 0, 1, 0);
      fetch(32'h9000_0000);
      exp_q.push_back('{32'h0, ERR_INTG, 1'b1});
      tick("err_b2b_2", 1, 0, 0, 1, 1);
      idle();
      tick("err_b2b_rsp", 0, 0, 0, 0, 1);

      // Region boundaries; both targets answer but only the decoded one is forwarded.
      for (int i = 0; i < 6; i++) begin
         logic [31:0] a;
         int          k;   // 0 ROM, 1 SRAM, 2 ERR
         case (i)
            0:       begin a = 32'h0000_0FFC; k = 0; end
            1:       begin a = 32'h0000_1000; k = 2; end
            2:       begin a = 32'h1000_FFFC; k = 1; end
            3:       begin a = 32'h1001_0000; k = 2; end
            4:       begin a = 32'h0FFF_FFFC; k = 2; end
            default: begin a = 32'hFFFF_FFFC; k = 2; end
         endcase
         idle(); fetch(a); rom_gnt_i = 1'b1; sram_gnt_i = 1'b1;
         case (k)
            0:       exp_q.push_back('{32'h5555_0000, ROM_INTG, 1'b0});
            1:       exp_q.push_back('{32'h6666_0000, SRAM_INTG, 1'b0});
            default: exp_q.push_back('{32'h0, ERR_INTG, 1'b1});
         endcase
         tick($sformatf("bnd%0d_gnt", i), 1, k == 0, k == 1, k == 2, 0);
         idle();
         rom_rvalid_i = 1'b1; rom_rdata_i = 32'h5555_0000;
         sram_rvalid_i = 1'b1; sram_rdata_i = 32'h6666_0000;
         tick($sformatf("bnd%0d_rsp", i), 0, 0, 0, 0, 1);
      end

      // Spurious responses: idle, and from a non-current target.
      idle(); rom_rvalid_i = 1'b1; sram_rvalid_i = 1'b1;
      tick("spur_idle", 0, 0, 0, 0, 0);
      idle(); fetch(32'h0000_0040); rom_gnt_i = 1'b1;
      exp_q.push_back('{32'h0000_0044, ROM_INTG, 1'b0});
      tick("spur_rom_gnt", 1, 1, 0, 0, 0);
      idle(); sram_rvalid_i = 1'b1; sram_rdata_i = 32'hDEAD_BEEF;
      tick("spur_sram", 0, 0, 0, 0, 0);
      idle(); rom_rvalid_i = 1'b1; rom_rdata_i = 32'h0000_0044;
      tick("spur_rom_rsp", 0, 0, 0, 0, 1);

      // Reset with two fetches in flight; late responses are dropped.
      idle(); fetch(32'h0000_0050); rom_gnt_i = 1'b1;
      tick("rr_g1", 1, 1, 0, 0, 0);
      fetch(32'h0000_0054);
      tick("rr_g2", 1, 1, 0, 0, 0);
      idle(); rst = 1'b0;
      tick("rr_reset", 0, 0, 0, 0, 0);
      rst = 1'b1; rom_rvalid_i = 1'b1; rom_rdata_i = 32'hBAD0_0001;
      tick("rr_late1", 0, 0, 0, 0, 0);
      rom_rdata_i = 32'hBAD0_0002;
      tick("rr_late2", 0, 0, 0, 0, 0);
      idle(); fetch(32'h1000_0100); sram_gnt_i = 1'b1;
      exp_q.push_back('{32'h0000_0100, SRAM_INTG, 1'b0});
      tick("rr_fresh", 1, 0, 1, 0, 0);
      idle(); sram_rvalid_i = 1'b1; sram_rdata_i = 32'h0000_0100;
      tick("rr_fresh_rsp", 0, 0, 0, 0, 1);

      // Zero-latency SRAM: grant and response in the same cycle.
      for (int i = 0; i < 3; i++) begin
         idle(); fetch(32'h1000_0200 + 32'(i * 4));
         sram_gnt_i = 1'b1; sram_rvalid_i = 1'b1; sram_rdata_i = 32'h2000_0000 + 32'(i);
         exp_q.push_back('{32'h2000_0000 + 32'(i), SRAM_INTG, 1'b0});
         tick($sformatf("zl%0d", i), 1, 0, 1, 0, 1);
      end
      // Count stayed at 0, so a ROM fetch is granted immediately.
      idle(); fetch(32'h0000_0060); rom_gnt_i = 1'b1;
      exp_q.push_back('{32'h0000_0066, ROM_INTG, 1'b0});
      tick("zl_then_rom", 1, 1, 0, 0, 0);
      idle(); rom_rvalid_i = 1'b1; rom_rdata_i = 32'h0000_0066; rom_err_i = 1'b0;
      tick("zl_then_rom_rsp", 0, 0, 0, 0, 1);

      idle();
      tick("drain", 0, 0, 0, 0, 0);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
